// File: rtl/custom_led_pkg.sv
// custom_led_pkg: shared constants for the custom_led register block.
//   LED_W_DEFAULT       default LED count / register width
//   ADDR_DATA/SET/CLR   word addresses of the DATA, SET and CLEAR registers
//   ADDR_BLINK          word address of the BLINK mask register
package custom_led_pkg;

   localparam int unsigned LED_W_DEFAULT = 10;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_SET   = 2'd1;
   localparam logic [1:0] ADDR_CLR   = 2'd2;
   localparam logic [1:0] ADDR_BLINK = 2'd3;

endpackage

// File: rtl/custom_led_blinker.sv
// custom_led_blinker: blink prescaler; phase toggles every BLINK_DIV clk cycles.
// Only compiled when CUSTOM_LED_BLINK_EN is defined.
//   clk      clock
//   reset_n  asynchronous active-low reset
//   phase    registered blink phase bit
`ifdef CUSTOM_LED_BLINK_EN
module custom_led_blinker #(
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset_n,
   output logic phase
);

   localparam int unsigned    CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Prescaler 0..BLINK_DIV-1; phase flips on each wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/custom_led.sv
// custom_led: memory-mapped LED register block (DATA / SET / CLEAR / BLINK).
// Optional blink feature compiled in by macro CUSTOM_LED_BLINK_EN.
//   clk, reset_n          clock, asynchronous active-low reset
//   chipselect, address   slave select, 2-bit word address
//   read, write           access strobes
//   writedata, readdata   32-bit data; bits above LED_W-1 ignored / read 0
//   led_out               registered active-high LED drive
module custom_led
   import custom_led_pkg::*;
#(
   parameter int unsigned LED_W     = LED_W_DEFAULT,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] led_out
);

   logic             wr_en;
   logic [LED_W-1:0] wd;
   logic [LED_W-1:0] data;
   logic [LED_W-1:0] blink_mask;
   logic             unused_wd;

   assign wr_en     = chipselect & write;
   assign wd        = writedata[LED_W-1:0];
   // Upper writedata bits are deliberately dropped
   assign unused_wd = ^writedata;

`ifdef CUSTOM_LED_BLINK_EN
   logic [LED_W-1:0] blink;
   logic             phase;

   custom_led_blinker #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blinker (
      .clk     (clk),
      .reset_n (reset_n),
      .phase   (phase)
   );

   assign blink_mask = blink & {LED_W{phase}};

   // BLINK mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink <= '0;
      end else if (wr_en && (address == ADDR_BLINK)) begin
         blink <= wd;
      end
   end
`else
   assign blink_mask = '0;
`endif

   // DATA register and registered LED drive (one cycle behind DATA)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data    <= '0;
         led_out <= '0;
      end else begin
         if (wr_en) begin
            case (address)
               ADDR_DATA: data <= wd;
               ADDR_SET:  data <= data | wd;
               ADDR_CLR:  data <= data & ~wd;
               default:   ;
            endcase
         end
         led_out <= data ^ blink_mask;
      end
   end

   // Zero-latency read mux; shows pre-write values on a simultaneous write
   always_comb begin
      readdata = '0;
      if (chipselect && read) begin
         case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR: readdata = 32'(data);
`ifdef CUSTOM_LED_BLINK_EN
            ADDR_BLINK:                    readdata = 32'(blink);
`endif
            default:                       readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_custom_led.sv
// tb_custom_led: directed bench for custom_led with a cycle-level reference
// model compared on every falling edge plus literal expectations.
module tb_custom_led;
   import custom_led_pkg::*;

   localparam int unsigned LW  = 10;
   localparam int unsigned DIV = 4;
`ifdef CUSTOM_LED_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          chipselect = 1'b0;
   logic [1:0]    address = 2'd0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = 32'h0;
   logic [31:0]   readdata;
   logic [LW-1:0] led_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   custom_led #(
      .LED_W     (LW),
      .BLINK_DIV (DIV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_out    (led_out)
   );

   // Reference model: register contents, LED drive, edges since reset
   logic [LW-1:0] m_data, m_blink, m_led, m_wv;
   int unsigned   m_k;
   bit            m_ph;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data  = '0;
         m_blink = '0;
         m_led   = '0;
         m_k     = 0;
      end else begin
         // phase after k edges is the parity of k / DIV
         m_ph  = ((m_k / DIV) % 2) == 1;
         m_led = m_data ^ (m_ph ? m_blink : '0);
         m_wv  = writedata[LW-1:0];
         if (chipselect && write) begin
            case (address)
               2'd0: m_data = m_wv;
               2'd1: m_data = m_data | m_wv;
               2'd2: m_data = m_data & ~m_wv;
               default: if (BLINK_ON) m_blink = m_wv;
            endcase
         end
         m_k++;
      end
   end

   function automatic logic [31:0] exp_rd();
      if (!(chipselect && read)) return 32'h0;
      if (address == 2'd3) return BLINK_ON ? 32'(m_blink) : 32'h0;
      return 32'(m_data);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("model_led_out", 32'(led_out), 32'(m_led));
      chk("model_readdata", readdata, exp_rd());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      step();
      chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
      step();
      chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
   endtask

   task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      chipselect = 1'b1; read = 1'b1; address = a;
      #1;
      chk(name, readdata, exp);
      chipselect = 1'b0; read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int toggles;
      logic prev;

      // Reset state
      #1;
      chk("reset_led", 32'(led_out), 32'h0);
      rd("reset_rd", ADDR_DATA, 32'h0);
      #10 reset_n = 1'b1;

      // Walking DATA writes
      wr(ADDR_DATA, 32'h001); step(); chk("led_001", 32'(led_out), 32'h001);
      wr(ADDR_DATA, 32'h002); step(); chk("led_002", 32'(led_out), 32'h002);
      wr(ADDR_DATA, 32'h004); step(); chk("led_004", 32'(led_out), 32'h004);
      rd("rd_data_004", ADDR_DATA, 32'h0000_0004);

      // SET / CLEAR
      wr(ADDR_DATA, 32'h0F0);
      wr(ADDR_SET,  32'h003); step(); chk("led_set", 32'(led_out), 32'h0F3);
      wr(ADDR_CLR,  32'h030); step(); chk("led_clr", 32'(led_out), 32'h0C3);
      rd("rd_set_addr", ADDR_SET, 32'h0C3);
      rd("rd_clr_addr", ADDR_CLR, 32'h0C3);

      // Simultaneous read and write shows pre-write value
      step();
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = ADDR_DATA; writedata = 32'h011;
      #1;
      chk("rw_prewrite", readdata, 32'h0C3);
      step();
      chk("rw_postwrite", readdata, 32'h011);
      chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
      step(); chk("led_rw", 32'(led_out), 32'h011);

      // Write and read without chipselect
      chipselect = 1'b0; write = 1'b1; read = 1'b1; address = ADDR_DATA; writedata = 32'h3FF;
      #1;
      chk("rd_no_cs", readdata, 32'h0);
      step();
      write = 1'b0; read = 1'b0; writedata = 32'h0;
      step(); chk("led_no_cs", 32'(led_out), 32'h011);
      rd("rd_no_cs_data", ADDR_DATA, 32'h011);

      // Upper writedata bits ignored
      wr(ADDR_DATA, 32'hFFFF_FD55);
      rd("rd_upper_ignored", ADDR_DATA, 32'h0000_0155);

      // Asynchronous reset between edges, then write pending across release
      wr(ADDR_DATA, 32'h3FF); step(); chk("led_3ff", 32'(led_out), 32'h3FF);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_led", 32'(led_out), 32'h0);
      rd("async_reset_rd", ADDR_DATA, 32'h0);
      chipselect = 1'b1; write = 1'b1; address = ADDR_DATA; writedata = 32'h2AA;
      #3 reset_n = 1'b1;
      step();
      chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
      step(); chk("led_after_release", 32'(led_out), 32'h2AA);

      // Blink on bit 0
      wr(ADDR_BLINK, 32'h001);
      wr(ADDR_DATA,  32'h000);
      step();
      prev = led_out[0];
      toggles = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("blink_upper_zero", 32'(led_out[LW-1:1]), 32'h0);
         if (led_out[0] != prev) toggles++;
         prev = led_out[0];
      end
      chk("blink_toggles", 32'(toggles), BLINK_ON ? 32'd4 : 32'd0);
      rd("rd_blink", ADDR_BLINK, BLINK_ON ? 32'h1 : 32'h0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/custom_led.md
CUSTOM_LED -- requirements
Module: custom_led

Interface
REQ-001 Parameter LED_W, default 10: number of LED outputs and width of every LED register; legal range 1..32.
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period; minimum 1.
REQ-003 clk  input  1: sole clock; all state changes on the rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 chipselect  input  1: slave select; read and write are ignored while low.
REQ-006 address  input  2: word address of the register map.
REQ-007 read  input  1: read strobe.
REQ-008 write  input  1: write strobe.
REQ-009 writedata  input  32: write data; bits above LED_W-1 are ignored.
REQ-010 readdata  output  32: read data; bits above LED_W-1 read 0.
REQ-011 led_out  output  LED_W: LED drive, active-high, registered.

Function
REQ-012 Register map: 0 DATA (RW), 1 SET (W, write-1-to-set DATA bits), 2 CLEAR (W, write-1-to-clear DATA bits), 3 BLINK mask (RW).
REQ-013 A write occurs on a rising edge with chipselect=1 and write=1; the new value is visible on led_out and readdata from the next edge; no wait states.
REQ-014 Write to DATA: DATA <= writedata[LED_W-1:0].
REQ-015 Write to SET: DATA <= DATA | writedata[LED_W-1:0]; to CLEAR: DATA <= DATA & ~writedata[LED_W-1:0].
REQ-016 Read is combinational, zero latency: readdata = selected register when chipselect=1 and read=1, else 32'h0.
REQ-017 SET and CLEAR read back the current DATA value.
REQ-018 When read and write are both asserted in the same cycle, the write is performed and readdata shows the pre-write value.
REQ-019 When write=1 and chipselect=0, no register changes.
REQ-020 led_out = DATA ^ (BLINK & {LED_W{phase}}), registered; phase is the blink phase bit (REQ-026).
REQ-021 Bits of led_out not selected by BLINK follow DATA exactly, with one cycle of latency after the write edge.

Reset
REQ-022 While reset_n=0: DATA, BLINK, prescaler, phase and led_out are all 0, independent of clk.
REQ-023 Deassertion of reset_n mid-transaction discards any access in that cycle; the first accepted write is on the first rising edge with reset_n=1.
REQ-024 readdata is combinational; it reads 0 during reset because all registers are 0.

Configuration
REQ-025 Macro CUSTOM_LED_BLINK_EN compiles in the blink feature.
REQ-026 With CUSTOM_LED_BLINK_EN defined: a prescaler counts 0..BLINK_DIV-1 and wraps to 0; phase toggles on each wrap; BLINK is read/write.
REQ-027 Without CUSTOM_LED_BLINK_EN: there is no prescaler; phase is constant 0; writes to address 3 are ignored; address 3 reads 0; led_out = DATA.

Structure
REQ-028 Package custom_led_pkg holds the address constants (ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_BLINK=3) and the default LED_W.
REQ-029 The prescaler and phase logic live in sub-module custom_led_blinker (ports clk, reset_n, phase), instantiated only under CUSTOM_LED_BLINK_EN.

Verification
REQ-030 Reset, then write DATA=0x001, 0x002, 0x004 in turn (one-cycle chipselect+write each) -> led_out is 0x001, 0x002, 0x004 on the edge after each write; reading address 0 then returns 0x00000004.
REQ-031 DATA=0x0F0, SET 0x003, then CLEAR 0x030 -> led_out 0x0F3 and then 0x0C3; reading addresses 1 and 2 returns 0x0C3.
REQ-032 write=1 with chipselect=0 and writedata=0x3FF -> led_out unchanged; read with chipselect=0 -> readdata 0.
REQ-033 Write DATA=0x155 with writedata[31:10] all ones -> readdata = 0x00000155.
REQ-034 Assert reset_n=0 asynchronously between edges while led_out=0x3FF -> led_out is 0 immediately, without waiting for a clock edge.
REQ-035 With CUSTOM_LED_BLINK_EN and BLINK_DIV=4: BLINK=0x001, DATA=0 -> led_out[0] toggles every 4 cycles and led_out[9:1] stays 0. Without the macro, the same writes give led_out=0 and address 3 reads 0.
